capture_sequencer: RTL and testbench
====================================

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 96000000, meaning per-frame capture watchdog limit in clock cycles (1 s at 96 MHz).
REQ-002 SHALL have ports:
- clock  in  1  96 MHz system clock; sole clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_cmd_single  in  1  one-cycle pulse; request one frame.
- in_cmd_continuous  in  1  level; capture frames back-to-back while high.
- in_cmd_stop  in  1  one-cycle pulse; abort or halt after the current state.
- in_cfg_write  in  1  one-cycle strobe; latch in_cfg_* into pending registers.
- in_cfg_width / in_cfg_height / in_cfg_exposure  in  16 each  requested image width, height and exposure.
- in_buffer0_addr / in_buffer1_addr  in  32 each  SDRAM frame-buffer base addresses.
- in_camera_ready  in  1  camera configured; level.
- in_captured  in  1  frame-complete level from the capture chain; synchronous to clock.
- out_start  out  1  one-cycle capture start pulse.
- out_width / out_height / out_exposure  out  16 each  active configuration, stable during a frame.
- out_buffer_addr  out  32  base address of the buffer being written.
- out_last_buffer  out  1  index of the most recently completed buffer.
- out_frame_count  out  16  completed-frame counter.
- out_busy  out  1  high in any state other than IDLE.
- out_timeout  out  1  sticky watchdog flag.

Function
REQ-003 FSM states SHALL be IDLE, WAIT_READY, START, CAPTURE, DONE.
REQ-004 IDLE SHALL go to WAIT_READY on in_cmd_single, or on in_cmd_continuous high, provided in_cmd_stop is low that cycle.
REQ-005 WAIT_READY SHALL go to START on the first cycle in_camera_ready is high and in_captured is low.
REQ-006 START SHALL last exactly one cycle with out_start=1, then go to CAPTURE; out_start SHALL be 0 in every other state.
REQ-007 CAPTURE SHALL go to DONE on a rising edge of in_captured (current 1, previous-cycle registered value 0).
REQ-008 DONE SHALL last one cycle and SHALL: increment out_frame_count (0xFFFF wraps to 0x0000); set out_last_buffer to the current buffer index; toggle the buffer index.
REQ-009 From DONE, the FSM SHALL go to WAIT_READY if in_cmd_continuous=1 and no stop is latched; otherwise it SHALL go to IDLE.
REQ-010 out_buffer_addr SHALL equal in_buffer0_addr when the index is 0 and in_buffer1_addr when the index is 1, registered one cycle.
REQ-011 in_cfg_write SHALL load pending registers in any state.
REQ-012 Pending values SHALL be copied to out_width/out_height/out_exposure only in IDLE or on the WAIT_READY entry cycle, never during START or CAPTURE; a write during a frame takes effect at the next frame.
REQ-013 in_cmd_stop in WAIT_READY or CAPTURE SHALL go to IDLE next cycle with no count increment and no buffer toggle.
REQ-014 in_cmd_stop in START or DONE SHALL be latched and applied at that state's exit.
REQ-015 When in_cmd_stop and in_cmd_single coincide, stop SHALL win.
REQ-016 A 32-bit watchdog SHALL clear on CAPTURE entry and count each CAPTURE cycle.
REQ-017 When the watchdog reaches TIMEOUT_CYCLES-1 with no capture edge, the block SHALL set out_timeout=1 and go to IDLE, with no count increment and no toggle, regardless of continuous mode.
REQ-018 out_timeout SHALL clear on the next accepted single or continuous start.
REQ-019 A capture edge and the timeout in the same cycle SHALL resolve as capture success.
REQ-020 in_camera_ready falling in START or CAPTURE SHALL return the FSM to WAIT_READY with no count increment and no toggle.
REQ-021 in_cmd_single while busy SHALL be ignored.

Reset
REQ-022 On reset_n=0, asynchronously: state=IDLE; out_start=0; out_busy=0; out_timeout=0; out_frame_count=0; buffer index=0; out_last_buffer=0; out_buffer_addr=0; pending and active config=0; watchdog=0; stop latch=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse on out_start during or after reset.

Verification
REQ-024 Ready=1, cfg write 640/480/1000, single pulse, in_captured rises 500 cycles after out_start -> exactly one out_start; out_frame_count=1; out_last_buffer=0; out_buffer_addr=buffer1; back to IDLE.
REQ-025 Continuous=1 for 3 frames, then deasserted -> out_frame_count=3; buffers alternate 0,1,0; out_last_buffer=0; IDLE.
REQ-026 Cfg write of width 320 during CAPTURE -> out_width stays 640 until the next WAIT_READY entry, then 320.
REQ-027 TIMEOUT_CYCLES=100, no in_captured -> out_timeout=1 at cycle 100 after CAPTURE entry; count unchanged; IDLE; next single clears out_timeout.
REQ-028 Stop coincident with single in IDLE -> no out_start. Stop in CAPTURE -> IDLE next cycle with no toggle.
REQ-029 reset_n low mid-CAPTURE with count=5 -> all outputs at reset values immediately; count=0.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer
//
// Frame-capture sequencer for a camera front end. It accepts single-shot or
// continuous capture commands, waits for the camera to be ready, and issues a
// one-cycle start pulse. It then waits for the rising edge of the
// frame-complete level and ping-pongs between two SDRAM frame buffers.
// A per-frame watchdog aborts a capture that never completes.
//
// Command semantics: there is no valid/ready handshake on this block. Commands
// are sampled every clock:
//   - in_cmd_single and in_cmd_stop are one-cycle pulses.
//   - in_cmd_continuous and in_camera_ready are levels.
//   - in_cfg_write is a one-cycle strobe that always loads the pending registers.
//   - A single pulse that arrives while busy is dropped.
//
// Ports
//   clock, reset_n              96 MHz clock, async active-low reset
//   in_cmd_single               request one frame (pulse)
//   in_cmd_continuous           capture frames back-to-back while high
//   in_cmd_stop                 abort / halt (pulse)
//   in_cfg_write, in_cfg_*      pending width/height/exposure load
//   in_buffer0/1_addr           frame-buffer base addresses
//   in_camera_ready             camera configured (level)
//   in_captured                 frame-complete level from capture chain
//   out_start                   one-cycle capture start pulse
//   out_width/height/exposure   active configuration for the current frame
//   out_buffer_addr             base address of the buffer being written
//   out_last_buffer             index of the most recently completed buffer
//   out_frame_count             completed-frame counter (wraps)
//   out_busy                    high outside IDLE
//   out_timeout                 sticky watchdog flag
//   debug_state                 current FSM state encoding
module capture_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 96000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_cmd_single,
    input  logic        in_cmd_continuous,
    input  logic        in_cmd_stop,
    input  logic        in_cfg_write,
    input  logic [15:0] in_cfg_width,
    input  logic [15:0] in_cfg_height,
    input  logic [15:0] in_cfg_exposure,
    input  logic [31:0] in_buffer0_addr,
    input  logic [31:0] in_buffer1_addr,
    input  logic        in_camera_ready,
    input  logic        in_captured,
    output logic        out_start,
    output logic [15:0] out_width,
    output logic [15:0] out_height,
    output logic [15:0] out_exposure,
    output logic [31:0] out_buffer_addr,
    output logic        out_last_buffer,
    output logic [15:0] out_frame_count,
    output logic        out_busy,
    output logic        out_timeout,
    output logic [2:0]  debug_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        START      = 3'd2,
        CAPTURE    = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 32'd1);

    state_t      state;
    state_t      next_state;
    logic        captured_q;
    logic        capture_edge;
    logic        stop_latch;
    logic        stop_any;
    logic [31:0] watchdog;
    logic        wd_expired;
    logic        timeout_hit;
    logic        start_accept;
    logic        load_cfg;
    logic        buf_idx;
    logic [15:0] pend_width;
    logic [15:0] pend_height;
    logic [15:0] pend_exposure;

    assign capture_edge = in_captured & ~captured_q;
    assign stop_any     = in_cmd_stop | stop_latch;
    assign wd_expired   = (watchdog == WD_LIMIT);
    assign start_accept = (state == IDLE) && (next_state == WAIT_READY);
    // Active config follows pending while idle, and is refreshed once more as
    // WAIT_READY is entered (including DONE -> WAIT_READY in continuous mode),
    // so it never moves while START/CAPTURE are using it.
    assign load_cfg     = (state == IDLE) ||
                          ((next_state == WAIT_READY) && (state != WAIT_READY));

    // ---------------- state register ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!in_cmd_stop && (in_cmd_single || in_cmd_continuous))
                    next_state = WAIT_READY;
            end
            WAIT_READY: begin
                if (in_cmd_stop)
                    next_state = IDLE;
                else if (in_camera_ready && !in_captured)
                    next_state = START;
            end
            START: begin
                if (stop_any)
                    next_state = IDLE;
                else if (!in_camera_ready)
                    next_state = WAIT_READY;
                else
                    next_state = CAPTURE;
            end
            CAPTURE: begin
                // The capture edge is checked before the watchdog, so a frame
                // that completes on the last allowed cycle still counts.
                if (in_cmd_stop) begin
                    next_state = IDLE;
                end else if (capture_edge) begin
                    next_state = DONE;
                end else if (!in_camera_ready) begin
                    next_state = WAIT_READY;
                end else if (wd_expired) begin
                    next_state  = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            DONE: begin
                if (in_cmd_continuous && !stop_any)
                    next_state = WAIT_READY;
                else
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        out_start   = (state == START);
        out_busy    = (state != IDLE);
        debug_state = state;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            captured_q      <= 1'b0;
            stop_latch      <= 1'b0;
            watchdog        <= 32'd0;
            out_timeout     <= 1'b0;
            out_frame_count <= 16'd0;
            buf_idx         <= 1'b0;
            out_last_buffer <= 1'b0;
            out_buffer_addr <= 32'd0;
            pend_width      <= 16'd0;
            pend_height     <= 16'd0;
            pend_exposure   <= 16'd0;
            out_width       <= 16'd0;
            out_height      <= 16'd0;
            out_exposure    <= 16'd0;
        end else begin
            captured_q <= in_captured;

            // A stop seen in a one-cycle state is held until the FSM is back
            // in IDLE, where it is dropped.
            if ((state == START) || (state == DONE))
                stop_latch <= stop_latch | in_cmd_stop;
            else
                stop_latch <= 1'b0;

            // Clearing in START means the first CAPTURE cycle sees zero.
            if (state == START)
                watchdog <= 32'd0;
            else if (state == CAPTURE)
                watchdog <= watchdog + 32'd1;

            if (start_accept)
                out_timeout <= 1'b0;
            else if (timeout_hit)
                out_timeout <= 1'b1;

            if (state == DONE) begin
                out_frame_count <= out_frame_count + 16'd1;
                out_last_buffer <= buf_idx;
                buf_idx         <= ~buf_idx;
            end

            out_buffer_addr <= buf_idx ? in_buffer1_addr : in_buffer0_addr;

            if (in_cfg_write) begin
                pend_width    <= in_cfg_width;
                pend_height   <= in_cfg_height;
                pend_exposure <= in_cfg_exposure;
            end

            if (load_cfg) begin
                out_width    <= pend_width;
                out_height   <= pend_height;
                out_exposure <= pend_exposure;
            end
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;

    localparam logic [31:0] B0 = 32'h1000_0000;
    localparam logic [31:0] B1 = 32'h2000_0000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        in_cmd_single, in_cmd_continuous, in_cmd_stop, in_cfg_write;
    logic [15:0] in_cfg_width, in_cfg_height, in_cfg_exposure;
    logic [31:0] in_buffer0_addr, in_buffer1_addr;
    logic        in_camera_ready, in_captured;

    logic        out_start, out_last_buffer, out_busy, out_timeout;
    logic [15:0] out_width, out_height, out_exposure, out_frame_count;
    logic [31:0] out_buffer_addr;
    logic [2:0]  debug_state;

    logic        wd_start, wd_last_buffer, wd_busy, wd_timeout;
    logic [15:0] wd_width, wd_height, wd_exposure, wd_frame_count;
    logic [31:0] wd_buffer_addr;
    logic [2:0]  wd_state;

    capture_sequencer u_dut (
        .clock(clock), .reset_n(reset_n),
        .in_cmd_single(in_cmd_single), .in_cmd_continuous(in_cmd_continuous),
        .in_cmd_stop(in_cmd_stop), .in_cfg_write(in_cfg_write),
        .in_cfg_width(in_cfg_width), .in_cfg_height(in_cfg_height),
        .in_cfg_exposure(in_cfg_exposure),
        .in_buffer0_addr(in_buffer0_addr), .in_buffer1_addr(in_buffer1_addr),
        .in_camera_ready(in_camera_ready), .in_captured(in_captured),
        .out_start(out_start), .out_width(out_width), .out_height(out_height),
        .out_exposure(out_exposure), .out_buffer_addr(out_buffer_addr),
        .out_last_buffer(out_last_buffer), .out_frame_count(out_frame_count),
        .out_busy(out_busy), .out_timeout(out_timeout), .debug_state(debug_state)
    );

    // Short-watchdog copy driven by the same stimulus.
    capture_sequencer #(.TIMEOUT_CYCLES(100)) u_dut_wd (
        .clock(clock), .reset_n(reset_n),
        .in_cmd_single(in_cmd_single), .in_cmd_continuous(in_cmd_continuous),
        .in_cmd_stop(in_cmd_stop), .in_cfg_write(in_cfg_write),
        .in_cfg_width(in_cfg_width), .in_cfg_height(in_cfg_height),
        .in_cfg_exposure(in_cfg_exposure),
        .in_buffer0_addr(in_buffer0_addr), .in_buffer1_addr(in_buffer1_addr),
        .in_camera_ready(in_camera_ready), .in_captured(in_captured),
        .out_start(wd_start), .out_width(wd_width), .out_height(wd_height),
        .out_exposure(wd_exposure), .out_buffer_addr(wd_buffer_addr),
        .out_last_buffer(wd_last_buffer), .out_frame_count(wd_frame_count),
        .out_busy(wd_busy), .out_timeout(wd_timeout), .debug_state(wd_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;
    int start_pulses = 0;

    always @(negedge clock) if (out_start === 1'b1) start_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        in_cmd_single = 1'b0; in_cmd_continuous = 1'b0; in_cmd_stop = 1'b0;
        in_cfg_write = 1'b0; in_captured = 1'b0; in_camera_ready = 1'b0;
        in_cfg_width = 16'd0; in_cfg_height = 16'd0; in_cfg_exposure = 16'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic cfg_write(input logic [15:0] w, input logic [15:0] h, input logic [15:0] e);
        in_cfg_width = w; in_cfg_height = h; in_cfg_exposure = e;
        in_cfg_write = 1'b1;
        step();
        in_cfg_write = 1'b0;
    endtask

    task automatic pulse_single();
        in_cmd_single = 1'b1;
        step();
        in_cmd_single = 1'b0;
    endtask

    // Steps until the selected instance is in START; bounded.
    task automatic wait_start(input bit use_wd, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ((use_wd ? wd_start : out_start) === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    // One continuous-mode frame; frame 0 also carries the mid-frame cfg write.
    task automatic do_frame(input int f);
        wait_start(1'b0, "b_wait_start");
        step();
        step(); step();
        check("b_buffer_addr", out_buffer_addr, (f == 1) ? B1 : B0);
        if (f == 0) begin
            cfg_write(16'd320, 16'd480, 16'd1000);
            step();
            check("b_state_capture", {29'd0, debug_state}, 32'd3);
            check("b_width_held_capture", {16'd0, out_width}, 32'd640);
        end
        if (f == 2) in_cmd_continuous = 1'b0;
        in_captured = 1'b1;
        step();
        check("b_state_done", {29'd0, debug_state}, 32'd4);
        if (f == 0) check("b_width_held_done", {16'd0, out_width}, 32'd640);
        step();
        in_captured = 1'b0;
        if (f < 2) check("b_state_wait_ready", {29'd0, debug_state}, 32'd1);
        else       check("b_state_idle", {29'd0, debug_state}, 32'd0);
        if (f == 0) check("b_width_new", {16'd0, out_width}, 32'd320);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        single, cont, stop, ready, captured;
        logic [2:0]  state;
        logic [15:0] fc;
        logic        last;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic c, input logic p, input logic r,
                       input logic cap, input logic [2:0] st, input logic [15:0] fc,
                       input logic last);
        vec_t v;
        v.single = s; v.cont = c; v.stop = p; v.ready = r; v.captured = cap;
        v.state = st; v.fc = fc; v.last = last;
        vecs.push_back(v);
    endtask

    int base;
    bit early;

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        in_buffer0_addr = B0;
        in_buffer1_addr = B1;

        // ---- reset state ----
        do_reset();
        check("rst_state", {29'd0, debug_state}, 32'd0);
        check("rst_busy", {31'd0, out_busy}, 32'd0);
        check("rst_start", {31'd0, out_start}, 32'd0);
        check("rst_timeout", {31'd0, out_timeout}, 32'd0);
        check("rst_frame_count", {16'd0, out_frame_count}, 32'd0);

        // ---- table: single cycle transitions (state after each edge) ----
        //   single cont stop ready capt | state fc last
        add(0,0,0,0,0, 0, 0, 0);
        add(1,0,1,1,0, 0, 0, 0);  // stop beats single
        add(0,0,1,1,0, 0, 0, 0);
        add(1,0,0,0,0, 1, 0, 0);  // accepted, camera not ready
        add(0,0,0,0,0, 1, 0, 0);
        add(0,0,0,1,1, 1, 0, 0);  // captured still high blocks start
        add(0,0,0,1,0, 2, 0, 0);
        add(0,0,0,1,0, 3, 0, 0);
        add(1,0,0,1,0, 3, 0, 0);  // single while busy ignored
        add(0,0,0,1,1, 4, 0, 0);  // capture rising edge
        add(0,0,0,1,1, 0, 1, 0);  // DONE: count, last=0
        add(0,0,0,1,0, 0, 1, 0);
        add(1,0,0,1,0, 1, 1, 0);
        add(0,0,0,1,0, 2, 1, 0);
        add(0,0,0,1,0, 3, 1, 0);
        add(0,0,1,1,0, 0, 1, 0);  // stop in CAPTURE
        add(1,0,0,1,0, 1, 1, 0);
        add(0,0,1,1,0, 0, 1, 0);  // stop in WAIT_READY
        add(1,0,0,1,0, 1, 1, 0);
        add(0,0,0,1,0, 2, 1, 0);
        add(0,0,0,0,0, 1, 1, 0);  // ready falls in START
        add(0,0,0,1,0, 2, 1, 0);
        add(0,0,1,1,0, 0, 1, 0);  // stop in START
        add(0,1,0,1,0, 1, 1, 0);
        add(0,1,0,1,0, 2, 1, 0);
        add(0,1,0,1,0, 3, 1, 0);
        add(0,1,0,0,0, 1, 1, 0);  // ready falls in CAPTURE
        add(0,1,0,1,0, 2, 1, 0);
        add(0,1,0,1,0, 3, 1, 0);
        add(0,1,0,1,1, 4, 1, 0);
        add(0,1,0,1,1, 1, 2, 1);  // continuous: DONE -> WAIT_READY
        add(0,1,0,1,1, 1, 2, 1);
        add(0,1,0,1,0, 2, 2, 1);
        add(0,1,0,1,0, 3, 2, 1);
        add(0,1,0,1,1, 4, 2, 1);
        add(0,1,1,1,1, 0, 3, 0);  // stop in DONE halts continuous
        add(0,0,0,1,0, 0, 3, 0);

        foreach (vecs[i]) begin
            in_cmd_single = vecs[i].single; in_cmd_continuous = vecs[i].cont;
            in_cmd_stop = vecs[i].stop; in_camera_ready = vecs[i].ready;
            in_captured = vecs[i].captured;
            step();
            check($sformatf("t%0d_state", i), {29'd0, debug_state}, {29'd0, vecs[i].state});
            check($sformatf("t%0d_start", i), {31'd0, out_start}, {31'd0, vecs[i].state == 3'd2});
            check($sformatf("t%0d_busy", i), {31'd0, out_busy}, {31'd0, vecs[i].state != 3'd0});
            check($sformatf("t%0d_count", i), {16'd0, out_frame_count}, {16'd0, vecs[i].fc});
            check($sformatf("t%0d_last", i), {31'd0, out_last_buffer}, {31'd0, vecs[i].last});
        end
        clear_inputs();

        // ---- single frame, capture 500 cycles after start ----
        do_reset();
        in_camera_ready = 1'b1;
        cfg_write(16'd640, 16'd480, 16'd1000);
        base = start_pulses;
        pulse_single();
        wait_start(1'b0, "a_wait_start");
        for (int i = 0; i < 500; i++) step();
        check("a_state_capture", {29'd0, debug_state}, 32'd3);
        in_captured = 1'b1;
        step();
        check("a_state_done", {29'd0, debug_state}, 32'd4);
        step();
        in_captured = 1'b0;
        step(); step(); step();
        check("a_start_pulses", start_pulses - base, 32'd1);
        check("a_frame_count", {16'd0, out_frame_count}, 32'd1);
        check("a_last_buffer", {31'd0, out_last_buffer}, 32'd0);
        check("a_buffer_addr", out_buffer_addr, B1);
        check("a_state_idle", {29'd0, debug_state}, 32'd0);
        check("a_width", {16'd0, out_width}, 32'd640);
        check("a_height", {16'd0, out_height}, 32'd480);
        check("a_exposure", {16'd0, out_exposure}, 32'd1000);

        // ---- continuous, 3 frames, cfg write mid-frame ----
        do_reset();
        in_camera_ready = 1'b1;
        cfg_write(16'd640, 16'd480, 16'd1000);
        step();
        check("b_width_initial", {16'd0, out_width}, 32'd640);
        in_cmd_continuous = 1'b1;
        for (int f = 0; f < 3; f++) do_frame(f);
        step();
        check("b_frame_count", {16'd0, out_frame_count}, 32'd3);
        check("b_last_buffer", {31'd0, out_last_buffer}, 32'd0);
        check("b_busy", {31'd0, out_busy}, 32'd0);

        // ---- watchdog (100-cycle instance) ----
        do_reset();
        in_camera_ready = 1'b1;
        pulse_single();
        wait_start(1'b1, "c_wait_start");
        step();                              // CAPTURE entry, cycle 0
        check("c_state_capture", {29'd0, wd_state}, 32'd3);
        early = 1'b0;
        for (int n = 1; n < 100; n++) begin
            step();
            if (wd_timeout !== 1'b0 || wd_state !== 3'd3) early = 1'b1;
        end
        check("c_no_early_timeout", {31'd0, early}, 32'd0);
        step();                              // cycle 100
        check("c_timeout_set", {31'd0, wd_timeout}, 32'd1);
        check("c_state_idle", {29'd0, wd_state}, 32'd0);
        check("c_count_unchanged", {16'd0, wd_frame_count}, 32'd0);
        check("c_last_unchanged", {31'd0, wd_last_buffer}, 32'd0);
        check("c_addr_no_toggle", wd_buffer_addr, B0);
        in_cmd_stop = 1'b1;                  // park the long-watchdog instance
        step();
        in_cmd_stop = 1'b0;
        check("c_timeout_sticky", {31'd0, wd_timeout}, 32'd1);
        pulse_single();
        check("c_timeout_cleared", {31'd0, wd_timeout}, 32'd0);
        check("c_restart_wait_ready", {29'd0, wd_state}, 32'd1);
        // Capture edge on the same cycle the watchdog expires: success wins.
        wait_start(1'b1, "c_wait_start2");
        step();
        for (int n = 1; n < 100; n++) step();
        in_captured = 1'b1;
        step();
        check("c_tie_done", {29'd0, wd_state}, 32'd4);
        check("c_tie_no_timeout", {31'd0, wd_timeout}, 32'd0);
        step();
        in_captured = 1'b0;
        step();
        check("c_tie_count", {16'd0, wd_frame_count}, 32'd1);
        check("c_tie_addr", wd_buffer_addr, B1);

        // ---- reset mid-CAPTURE with count 5 ----
        do_reset();
        in_camera_ready = 1'b1;
        cfg_write(16'd640, 16'd480, 16'd1000);
        for (int k = 0; k < 5; k++) begin
            pulse_single();
            wait_start(1'b0, "d_wait_start");
            step();
            in_captured = 1'b1;
            step(); step();
            in_captured = 1'b0;
        end
        check("d_count_5", {16'd0, out_frame_count}, 32'd5);
        pulse_single();
        wait_start(1'b0, "d_wait_start6");
        step(); step();
        check("d_state_capture", {29'd0, debug_state}, 32'd3);
        base = start_pulses;
        #2;
        reset_n = 1'b0;
        #1;
        check("d_rst_state", {29'd0, debug_state}, 32'd0);
        check("d_rst_start", {31'd0, out_start}, 32'd0);
        check("d_rst_busy", {31'd0, out_busy}, 32'd0);
        check("d_rst_timeout", {31'd0, out_timeout}, 32'd0);
        check("d_rst_count", {16'd0, out_frame_count}, 32'd0);
        check("d_rst_last", {31'd0, out_last_buffer}, 32'd0);
        check("d_rst_addr", out_buffer_addr, 32'd0);
        check("d_rst_width", {16'd0, out_width}, 32'd0);
        check("d_rst_height", {16'd0, out_height}, 32'd0);
        check("d_rst_exposure", {16'd0, out_exposure}, 32'd0);
        step(); step(); step();
        reset_n = 1'b1;
        step(); step(); step();
        check("d_no_start_pulse", start_pulses - base, 32'd0);
        check("d_idle_after", {31'd0, out_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
